// File: rtl/div_pkg.sv
// Shared constants for the iterative divider: FSM encodings, handshake levels
// and the ALU op codes EX decodes into a divide request.
package div_pkg;

  localparam int REG_BUS_W        = 32;
  localparam int DOUBLE_REG_BUS_W = 64;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // Two's-complement magnitude of a possibly-signed operand.
  function automatic logic [REG_BUS_W-1:0] mag(input logic is_signed,
                                               input logic [REG_BUS_W-1:0] v);
    return (is_signed && v[REG_BUS_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// sign-magnitude operands, result {remainder, quotient} held until EX drops start.
module div
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int CW = $clog2(DATA_W) + 1;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] rem, dvd, dvs;
  logic              q_neg, r_neg;
  logic              op1_neg, op2_neg;
  logic [DATA_W-1:0] op1_mag, op2_mag;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W+1:0] diff;

  assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign op1_mag = op1_neg ? -opdata1_i : opdata1_i;
  assign op2_mag = op2_neg ? -opdata2_i : opdata2_i;

  // The shifted remainder can reach DATA_W+1 bits for large unsigned divisors,
  // so the subtract carries one extra bit to keep the sign exact.
  assign rem_sh = {rem, dvd[DATA_W-1]};
  assign diff   = {1'b0, rem_sh} - {2'b00, dvs};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DivFree;
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      ready_o  <= DivResultNotReady;
      result_o <= '0;
    end else begin
      case (state)
        DivFree: begin
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DivByZero;
            end else begin
              state <= DivOn;
              cnt   <= '0;
              rem   <= '0;
              dvd   <= op1_mag;
              dvs   <= op2_mag;
              q_neg <= op1_neg ^ op2_neg;
              r_neg <= op1_neg;
            end
          end
        end
        DivByZero: begin
          state    <= DivEnd;
          result_o <= '0;
        end
        DivOn: begin
          if (annul_i) begin
            state <= DivFree;
            cnt   <= '0;
          end else if (cnt != CW'(DATA_W)) begin
            // Quotient bits shift into dvd from the bottom as dividend bits leave the top.
            rem <= diff[DATA_W+1] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
            dvd <= {dvd[DATA_W-2:0], ~diff[DATA_W+1]};
            cnt <= cnt + 1'b1;
          end else begin
            result_o <= {(r_neg ? -rem : rem), (q_neg ? -dvd : dvd)};
            ready_o  <= DivResultReady;
            state    <= DivEnd;
            cnt      <= '0;
          end
        end
        DivEnd: begin
          // Divide-by-zero arrives here without ready; raise it on the first END edge.
          if (ready_o == DivResultNotReady) begin
            ready_o <= DivResultReady;
          end else if (start_i == DivStop) begin
            state    <= DivFree;
            ready_o  <= DivResultNotReady;
            result_o <= '0;
          end
        end
        default: state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: driver pushes reference results, monitor pops on
// each rising ready_o and checks value and latency.
module tb_div;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  div #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] exp;
    int          lat;
    int          issue;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic ready_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, qq, rr;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    la = longint'($signed(a));
    lb = longint'($signed(b));
    qq = la / lb;
    rr = la % lb;
    return {rr[31:0], qq[31:0]};
  endfunction

  // Monitor: every rising ready_o must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst && ready_o && !ready_q) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ready: result=%h with nothing outstanding", result_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (result_o !== e.exp || (cyc - e.issue) != e.lat) begin
          n_err++;
          $display("FAIL result: got %h lat %0d, want %h lat %0d",
                   result_o, cyc - e.issue, e.exp, e.lat);
        end
      end
    end
    ready_q <= ready_o;
  end

  task automatic check(input string name, input logic [64:0] got, input logic [64:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b, input bit push);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    if (push) q.push_back('{exp: model(sgn, a, b), lat: (b == 32'd0) ? 2 : 33, issue: cyc + 1});
  endtask

  task automatic wait_ready(output bit ok);
    int t = 0;
    @(negedge clk);
    // Operands may change once accepted; the DUT must ignore them.
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~signed_div_i;
    while (!ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    ok = ready_o;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: ready_o never rose");
      q.delete();
    end
  endtask

  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
    bit          ok;
    logic [63:0] e;
    e = model(sgn, a, b);
    issue(sgn, a, b, 1'b1);
    wait_ready(ok);
    if (ok) begin
      repeat (hold) begin
        @(negedge clk);
        check("hold", {ready_o, result_o}, {1'b1, e});
      end
    end
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("release", {ready_o, result_o}, 65'd0);
  endtask

  initial begin
    bit          ok;
    int          seen;
    logic [31:0] a, b;

    #12;
    check("reset_state", {ready_o, result_o}, 65'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op(1'b0, 32'd100, 32'd7, 3);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1);
    run_op(1'b0, 32'd5, 32'd0, 2);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0);

    // Annul at cnt=10, then a fresh request must complete normally.
    issue(1'b0, 32'd1000, 32'd3, 1'b0);
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) seen++;
    end
    check("annul_no_ready", 65'(seen), 65'd0);
    run_op(1'b0, 32'd9, 32'd3, 1);

    // Simultaneous start and annul in FREE is dropped.
    issue(1'b0, 32'd50, 32'd5, 1'b0);
    annul_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) seen++;
    end
    check("start_annul_ignored", 65'(seen), 65'd0);

    // Async reset while the result is being held.
    issue(1'b0, 32'd77, 32'd8, 1'b1);
    wait_ready(ok);
    #2 rst = 1'b0;
    #1 check("reset_in_end", {ready_o, result_o}, 65'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Async reset mid-iteration discards the work.
    issue(1'b1, 32'd123456, 32'd789, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("reset_in_on", {ready_o, result_o}, 65'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_op(1'b0, 32'd20, 32'd6, 1);

    for (int i = 0; i < 24; i++) begin
      a = ($urandom % 6 == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom % 8)
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom % 16);
        default: b = 32'($urandom);
      endcase
      run_op(1'($urandom % 2), a, b, int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d results never arrived", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
